// File: rtl/fft_agu_param_pkg.sv
// Shared constants for the FFT address generation unit: operand tags and FSM states.
// No logic; pure definitions.
// Consumed by fft_agu_param and its address calculator.
package fft_agu_param_pkg;

  // Operand tags, in the order the six reads of a butterfly are issued
  localparam logic [2:0] SLOT_BR   = 3'd0;
  localparam logic [2:0] SLOT_WR   = 3'd1;
  localparam logic [2:0] SLOT_BI   = 3'd2;
  localparam logic [2:0] SLOT_WI   = 3'd3;
  localparam logic [2:0] SLOT_AR   = 3'd4;
  localparam logic [2:0] SLOT_AI   = 3'd5;
  localparam logic [2:0] SLOT_LAST = 3'd7;

  // Write steps in the flush window after the last butterfly of a stage
  localparam logic [1:0] FLUSH_LAST = 2'd3;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fft_agu_addr_calc.sv
// Butterfly address math: (stage, butterfly, inverse) -> upper/lower data and twiddle word addresses.
// Purely combinational, zero latency.
// No flow control; the parent decides when the results are used.
module fft_agu_addr_calc #(
  parameter int LOG_N     = 3,
  parameter int ADDR_W    = 10,
  parameter int DATA_BASE = 16,
  parameter int TW_BASE   = 0,
  localparam int SW       = $clog2(LOG_N) + 1,
  localparam int BW       = LOG_N - 1
) (
  input  logic [SW-1:0]     s,
  input  logic [BW-1:0]     b,
  input  logic              inverse,
  output logic [ADDR_W-1:0] upper,
  output logic [ADDR_W-1:0] lower,
  output logic [ADDR_W-1:0] tw
);

  logic [ADDR_W-1:0] b_w;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] up_idx;
  logic [ADDR_W-1:0] tw_idx;
  logic [ADDR_W-1:0] tw_off;

  // Split b into group and in-group offset, then form real-part word addresses (imag is +1)
  always_comb begin
    b_w    = ADDR_W'(b);
    span   = ADDR_W'(1) << s;
    mask   = span - ADDR_W'(1);
    up_idx = ((b_w >> s) << (s + SW'(1))) | (b_w & mask);
    tw_idx = (b_w & mask) << (SW'(LOG_N - 1) - s);
    tw_off = inverse ? (ADDR_W'(1) << LOG_N) : '0;
    upper  = ADDR_W'(DATA_BASE) + (up_idx << 1);
    lower  = ADDR_W'(DATA_BASE) + ((up_idx + span) << 1);
    tw     = ADDR_W'(TW_BASE) + tw_off + (tw_idx << 1);
  end

endmodule

// File: rtl/fft_agu_param.sv
// In-place radix-2 FFT/IFFT address sequencer: six operand reads per butterfly, four delayed result writes.
// Read of slot k registered one cycle after the slot is sequenced; first read the cycle after start is taken.
// stall freezes all sequencing and suppresses rd_en/wr_en; addresses hold and resume exactly where stopped.
module fft_agu_param
  import fft_agu_param_pkg::*;
#(
  parameter int LOG_N     = 3,
  parameter int ADDR_W    = 10,
  parameter int DATA_BASE = 2 * (1 << LOG_N),
  parameter int TW_BASE   = 0,
  localparam int SW       = $clog2(LOG_N) + 1,
  localparam int BW       = LOG_N - 1
) (
  input  logic              controlPulse,
  input  logic              reset,
  input  logic              start,
  input  logic              inverse,
  input  logic              stall,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [2:0]        rd_slot,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     stage,
  output logic [BW-1:0]     op_count
);

  logic [1:0]        state;
  logic [2:0]        slot;
  logic [1:0]        fcnt;
  logic              inv_q;
  logic [ADDR_W-1:0] up_a;
  logic [ADDR_W-1:0] lo_a;
  logic [ADDR_W-1:0] tw_a;
  logic [ADDR_W-1:0] wr_up;
  logic [ADDR_W-1:0] wr_lo;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W-1:0] wr_next;
  logic              rd_hit;
  logic              wr_hit;
  logic [1:0]        wsel;

  fft_agu_addr_calc #(
    .LOG_N     (LOG_N),
    .ADDR_W    (ADDR_W),
    .DATA_BASE (DATA_BASE),
    .TW_BASE   (TW_BASE)
  ) u_calc (
    .s       (stage),
    .b       (op_count),
    .inverse (inv_q),
    .upper   (up_a),
    .lower   (lo_a),
    .tw      (tw_a)
  );

  // Select the operand address for the current slot; slots 6 and 7 are idle on the read bus
  always_comb begin
    rd_hit  = 1'b1;
    rd_next = '0;
    case (slot)
      SLOT_BR: rd_next = lo_a;
      SLOT_WR: rd_next = tw_a;
      SLOT_BI: rd_next = lo_a + ADDR_W'(1);
      SLOT_WI: rd_next = tw_a + ADDR_W'(1);
      SLOT_AR: rd_next = up_a;
      SLOT_AI: rd_next = up_a + ADDR_W'(1);
      default: rd_hit  = 1'b0;
    endcase
  end

  // Previous butterfly's results go out in slots 0..3 (none before b=0), or in the four flush steps
  always_comb begin
    if (state == ST_FLUSH) begin
      wsel   = fcnt;
      wr_hit = 1'b1;
    end else begin
      wsel   = slot[1:0];
      wr_hit = (op_count != '0) && !slot[2];
    end
    wr_next = (wsel[1] ? wr_lo : wr_up) + ADDR_W'(wsel[0]);
  end

  // Sequencer: FSM, slot/butterfly/stage counters, write-address pipeline and registered outputs
  always_ff @(posedge controlPulse or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      slot     <= '0;
      fcnt     <= '0;
      inv_q    <= 1'b0;
      stage    <= '0;
      op_count <= '0;
      wr_up    <= '0;
      wr_lo    <= '0;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      rd_slot  <= '0;
      wr_addr  <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            busy     <= 1'b1;
            inv_q    <= inverse;
            stage    <= '0;
            op_count <= '0;
            slot     <= '0;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (rd_hit) begin
              rd_en   <= 1'b1;
              rd_addr <= rd_next;
              rd_slot <= slot;
            end
            if (wr_hit) begin
              wr_en   <= 1'b1;
              wr_addr <= wr_next;
            end
            slot <= slot + 3'd1;
            if (slot == SLOT_LAST) begin
              wr_up <= up_a;
              wr_lo <= lo_a;
              if (op_count == '1) begin
                state <= ST_FLUSH;
                fcnt  <= '0;
              end else begin
                op_count <= op_count + BW'(1);
              end
            end
          end
        end
        ST_FLUSH: begin
          if (!stall) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_next;
            fcnt    <= fcnt + 2'd1;
            if (fcnt == FLUSH_LAST) begin
              op_count <= '0;
              slot     <= '0;
              if (stage == SW'(LOG_N - 1)) begin
                state <= ST_DONE;
              end else begin
                stage <= stage + SW'(1);
                state <= ST_RUN;
              end
            end
          end
        end
        ST_DONE: begin
          if (!stall) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_agu_param.sv
// Bench for fft_agu_param with N=8, DATA_BASE=16, TW_BASE=0.
// Expectations are time-stamped and queued; a negedge monitor checks every entry due in the current cycle.
// Stimulus is directed; expected addresses are hand-computed from the butterfly index math.
module tb_fft_agu_param;

  localparam int LOG_N  = 3;
  localparam int ADDR_W = 10;
  localparam int SW     = $clog2(LOG_N) + 1;
  localparam int BW     = LOG_N - 1;

  localparam int K_RD     = 0;
  localparam int K_NORD   = 1;
  localparam int K_WR     = 2;
  localparam int K_NOWR   = 3;
  localparam int K_DONE   = 4;
  localparam int K_NODONE = 5;
  localparam int K_BUSY   = 6;
  localparam int K_SB     = 7;
  localparam int K_ZERO   = 8;
  localparam int K_DCNT   = 9;
  localparam int K_EMPTY  = 10;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  logic              controlPulse;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              inverse = 1'b0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [2:0]        rd_slot;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic [SW-1:0]     stage;
  logic [BW-1:0]     op_count;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   t0;

  fft_agu_param #(
    .LOG_N     (LOG_N),
    .ADDR_W    (ADDR_W),
    .DATA_BASE (16),
    .TW_BASE   (0)
  ) dut (
    .controlPulse (controlPulse),
    .reset        (reset),
    .start        (start),
    .inverse      (inverse),
    .stall        (stall),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_slot      (rd_slot),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .busy         (busy),
    .done         (done),
    .stage        (stage),
    .op_count     (op_count)
  );

  initial begin
    controlPulse = 1'b0;
    forever #5 controlPulse = ~controlPulse;
  end

  always @(posedge controlPulse) cyc <= cyc + 1;

  task automatic push(input int c, input int k, input int v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input int c, input int addr, input int tag);
    push(c, K_RD, tag * 4096 + addr);
  endtask

  // Six reads of one butterfly window: br, wr, bi, wi, ar, ai
  task automatic push_win(input int c, input int br, input int wr, input int ar);
    push_rd(c,     br,     0);
    push_rd(c + 1, wr,     1);
    push_rd(c + 2, br + 1, 2);
    push_rd(c + 3, wr + 1, 3);
    push_rd(c + 4, ar,     4);
    push_rd(c + 5, ar + 1, 5);
  endtask

  // Four result writes: r1r, r1i (upper), r2r, r2i (lower)
  task automatic push_wr4(input int c, input int up, input int lo);
    push(c,     K_WR, up);
    push(c + 1, K_WR, up + 1);
    push(c + 2, K_WR, lo);
    push(c + 3, K_WR, lo + 1);
  endtask

  task automatic push_none(input int c, input int n, input int k);
    for (int i = 0; i < n; i++) push(c + i, k, 0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge controlPulse);
  endtask

  task automatic pulse_start(input logic inv);
    int c;
    c       = cyc + 1;
    start   = 1'b1;
    inverse = inv;
    wait_until(c);
    start   = 1'b0;
    inverse = 1'b0;
  endtask

  task automatic do_check(input exp_t e);
    logic [31:0] got;
    logic [31:0] want;
    string       nm;
    got  = '0;
    want = '0;
    nm   = "unknown";
    case (e.kind)
      K_RD: begin
        nm   = "rd";
        got  = (32'(rd_en) << 16) | (32'(rd_slot) << 12) | 32'(rd_addr);
        want = 32'h10000 | 32'(e.val);
      end
      K_NORD:   begin nm = "no_rd";   got = 32'(rd_en); want = 0; end
      K_WR: begin
        nm   = "wr";
        got  = (32'(wr_en) << 12) | 32'(wr_addr);
        want = 32'h1000 | 32'(e.val);
      end
      K_NOWR:   begin nm = "no_wr";   got = 32'(wr_en); want = 0; end
      K_DONE:   begin nm = "done";    got = 32'(done);  want = 1; end
      K_NODONE: begin nm = "no_done"; got = 32'(done);  want = 0; end
      K_BUSY:   begin nm = "busy";    got = 32'(busy);  want = 32'(e.val); end
      K_SB: begin
        nm   = "stage_op";
        got  = (32'(stage) << 4) | 32'(op_count);
        want = 32'(e.val);
      end
      K_ZERO: begin
        nm   = "reset_zero";
        got  = 32'({rd_addr, rd_en, rd_slot, wr_addr, wr_en, busy, done, stage, op_count});
        want = 0;
      end
      K_DCNT:  begin nm = "done_count"; got = 32'(done_cnt); want = 32'(e.val); end
      K_EMPTY: begin nm = "leftover";   got = 32'(exp_q.size() - 1); want = 0; end
      default: begin nm = "bad_kind";   got = 32'(e.kind); want = 0; end
    endcase
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, got, want);
    end
  endtask

  // Monitor: count done pulses and check every expectation due this cycle
  always @(negedge controlPulse) begin
    if (done === 1'b1) done_cnt++;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        do_check(exp_q[i]);
        exp_q.delete(i);
      end
    end
  end

  initial begin
    // Reset state, during and right after reset
    push(2, K_ZERO, 0);
    push(5, K_ZERO, 0);
    push(6, K_BUSY, 0);
    wait_until(4);
    reset = 1'b0;
    wait_until(8);

    // A: forward run, with a stray start while busy
    t0 = cyc + 1;
    push(t0 + 1, K_BUSY, 1);
    push(t0 + 1, K_SB, 0);
    push_win(t0 + 1, 18, 0, 16);
    push_none(t0 + 7, 2, K_NORD);
    push_none(t0 + 1, 8, K_NOWR);
    push_wr4(t0 + 9, 16, 18);
    push_rd(t0 + 9, 22, 0);
    push_none(t0 + 33, 4, K_NORD);
    push_wr4(t0 + 33, 28, 30);
    push_win(t0 + 45, 22, 4, 18);
    push(t0 + 46, K_SB, 16 + 1);
    push_win(t0 + 97, 30, 6, 22);
    push_wr4(t0 + 105, 22, 30);
    push(t0 + 108, K_BUSY, 1);
    push(t0 + 108, K_NODONE, 0);
    push(t0 + 109, K_DONE, 0);
    push(t0 + 109, K_BUSY, 0);
    push(t0 + 110, K_NODONE, 0);
    push(t0 + 116, K_DCNT, 1);
    pulse_start(1'b0);
    wait_until(t0 + 19);
    start   = 1'b1;
    inverse = 1'b1;
    wait_until(t0 + 20);
    start   = 1'b0;
    inverse = 1'b0;
    wait_until(t0 + 117);

    // B: inverse run selects the second twiddle table
    t0 = cyc + 1;
    push_rd(t0 + 1, 18, 0);
    push_rd(t0 + 2, 8, 1);
    push_rd(t0 + 4, 9, 3);
    push_win(t0 + 45, 22, 12, 18);
    push(t0 + 109, K_DONE, 0);
    push(t0 + 111, K_DCNT, 2);
    pulse_start(1'b1);
    wait_until(t0 + 112);

    // C: five stalled cycles at slot 2 of the first window
    t0 = cyc + 1;
    push_rd(t0 + 1, 18, 0);
    push_rd(t0 + 2, 0, 1);
    push_none(t0 + 3, 5, K_NORD);
    push_none(t0 + 3, 5, K_NOWR);
    push(t0 + 5, K_BUSY, 1);
    push(t0 + 5, K_SB, 0);
    push_rd(t0 + 8, 19, 2);
    push_rd(t0 + 9, 1, 3);
    push_rd(t0 + 10, 16, 4);
    push_rd(t0 + 11, 17, 5);
    push_none(t0 + 12, 2, K_NORD);
    push_wr4(t0 + 14, 16, 18);
    push(t0 + 109, K_NODONE, 0);
    push(t0 + 113, K_NODONE, 0);
    push(t0 + 114, K_DONE, 0);
    push(t0 + 116, K_DCNT, 3);
    pulse_start(1'b0);
    wait_until(t0 + 2);
    stall = 1'b1;
    wait_until(t0 + 7);
    stall = 1'b0;
    wait_until(t0 + 117);

    // D: asynchronous reset mid-cycle abandons the transform
    t0 = cyc + 1;
    push_win(t0 + 1, 18, 0, 16);
    push_rd(t0 + 45, 22, 0);
    push_rd(t0 + 49, 18, 4);
    push(t0 + 50, K_ZERO, 0);
    push(t0 + 51, K_ZERO, 0);
    push(t0 + 119, K_DCNT, 3);
    pulse_start(1'b0);
    wait_until(t0 + 49);
    @(posedge controlPulse);
    #3 reset = 1'b1;
    wait_until(t0 + 52);
    reset = 1'b0;
    wait_until(t0 + 120);

    // E: a fresh start after reset reproduces the first window
    t0 = cyc + 1;
    push_win(t0 + 1, 18, 0, 16);
    push_none(t0 + 7, 2, K_NORD);
    push_none(t0 + 1, 8, K_NOWR);
    push_wr4(t0 + 9, 16, 18);
    push(t0 + 109, K_DONE, 0);
    push(t0 + 111, K_DCNT, 4);
    push(t0 + 113, K_EMPTY, 0);
    pulse_start(1'b0);
    wait_until(t0 + 115);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_agu_param.md
# fft_agu_param

Parametrised address generation unit for the in-place radix-2 FFT/IFFT datapath. It sequences every stage and butterfly of an N-point transform on its own and issues the six operand read addresses per butterfly (br, wr, bi, wi, ar, ai). It also issues the four delayed result write addresses (r1r, r1i, r2r, r2i) and signals completion. It sits between the FFT controller and the shared data/twiddle RAM address buses.

## Interface
- LOG_N, 3: log2 of transform size N; N/2 butterflies per stage, LOG_N stages.
- ADDR_W, 10: RAM address width; must cover DATA_BASE+2N-1 and TW_BASE+2N-1.
- DATA_BASE, 2N: word offset of interleaved complex data (re at even, im at odd).
- TW_BASE, 0: word offset of twiddle tables; forward table N words, inverse table the next N words.

Ports:
- controlPulse  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces idle.
- start  in  1  one-cycle request; sampled only in IDLE.
- inverse  in  1  selects inverse twiddle table; latched on accepted start.
- stall  in  1  freezes sequencing while high.
- rd_addr  out  ADDR_W  registered operand read address.
- rd_en  out  1  rd_addr valid this cycle.
- rd_slot  out  3  operand tag: 0 br, 1 wr, 2 bi, 3 wi, 4 ar, 5 ai.
- wr_addr  out  ADDR_W  registered result write address.
- wr_en  out  1  wr_addr valid this cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- stage  out  $clog2(LOG_N)+1  current stage s.
- op_count  out  LOG_N-1  current butterfly index b.

## Operation
- States: IDLE -> RUN on start. RUN -> FLUSH after slot 7 of butterfly N/2-1. FLUSH -> RUN after 4 cycles if s < LOG_N-1, with s+1 and b=0. FLUSH -> DONE otherwise. DONE -> IDLE after 1 cycle.
- RUN window: 8 slots per butterfly, slot counter 0..7.
  - Slots 0..5 issue reads in tag order.
  - Slots 6..7 issue no read.
- Address math for stage s, butterfly b, span=2^s:
  - upper = ((b>>s)<<(s+1)) | (b & (span-1)); lower = upper+span.
  - tw = (b & (span-1)) << (LOG_N-1-s).
  - Data word = DATA_BASE + 2*index + im.
  - Twiddle word = TW_BASE + (inverse<<LOG_N) + 2*tw + im.
  - Unsigned; the result must fit ADDR_W with no wrap.
- Writes for butterfly k are issued in slots 0..3 of the following window: r1r, r1i (upper), r2r, r2i (lower).
- The last butterfly of each stage writes in the 4 FLUSH cycles. No reads occur in FLUSH, so a stage never reads an address with a pending write.
- stall high:
  - Slot counter, b, s and state hold.
  - rd_en and wr_en are 0; addresses hold.
  - Sequencing resumes exactly where it stopped.
- start while not IDLE: ignored. start and stall together in IDLE: start is accepted, and the first slot waits for stall low.
- Reset values:
  - All outputs 0, state IDLE, s=0, b=0, slot=0.
  - Reset mid-operation abandons the transform with no done pulse.

## Timing
- Accepted start at edge T: first read (br of s0 b0) is valid in cycle T+1.
- All outputs are registered; one issue per cycle at most on each bus.
- Unstalled run length from T+1 to the last wr_en: LOG_N*(4N+4) cycles. done is high the cycle after; busy drops with done.
- Example, N=8: 108 cycles; done at T+109.

## Structure
- The shared defines header holds the slot tag constants (BR..AI) and the state encodings.
- Sub-module fft_agu_addr_calc: purely combinational (s, b, inverse) -> upper, lower, tw word addresses. The parent holds the FSM, counters, write-address pipeline register and output registers.

## Test plan
All scenarios use N=8, DATA_BASE=16, TW_BASE=0.
- start, inverse=0 -> reads T+1..T+6 are 18, 0, 19, 1, 16, 17 with tags 0..5; no wr_en in the first window.
- Window of s0 b1, slots 0..3 -> wr_addr 16, 17, 18, 19 with wr_en high.
- Stage 1, b=1 -> reads 22, 4, 23, 5, 18, 19. The same run with inverse=1 -> wr=12, wi=13.
- stall high for 5 cycles at slot 2 -> rd_en=0 and wr_en=0 throughout; resumes with slot 2 (bi); total length grows by exactly 5.
- reset asserted at cycle 50, asynchronously mid-cycle -> all outputs 0 immediately and no done. A new start then reproduces the first scenario.
- start pulsed at cycle 20 while busy -> ignored; done at T+109 exactly once.
